decrement_range_streamer: RTL

Streams a descending count sequence start, start-1, …, end over a valid/ready interface after accepting one (start, end) configuration through a separate valid/ready handshake. It is the consumer-paced, downward-counting counterpart of the free-running increment-then-stop counter. It drives reverse-order address and index walks, such as weight or row readback in the MNIST datapath. Signals completion with a one-cycle `done_o` pulse and rejects malformed ranges with `err_o`.

---
 rtl/decrement_range_streamer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/decrement_range_streamer.sv
// +--------------------------------------------------------------------------+
// | decrement_range_streamer                                                 |
// | Streams start..end downward over valid/ready after one config handshake. |
// | Optional: DECREMENT_RANGE_STREAMER_ASSERT_EN enables sim-only checks.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module decrement_range_streamer #(
  parameter int Bits = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cfg_valid_i,
  output logic            cfg_ready_o,
  input  logic [Bits-1:0] start_val_i,
  input  logic [Bits-1:0] end_val_i,
  output logic            count_valid_o,
  input  logic            count_ready_i,
  output logic [Bits-1:0] count_o,
  output logic            last_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t          state_q;
  logic [Bits-1:0] end_q;
  logic [Bits-1:0] count_q;
  logic            cfg_ready_q;
  logic            count_valid_q;
  logic            last_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic [Bits-1:0] count_minus1;

  assign count_minus1 = count_q - 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      end_q         <= '0;
      count_q       <= '0;
      cfg_ready_q   <= 1'b1;
      count_valid_q <= 1'b0;
      last_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cfg_valid_i && cfg_ready_q) begin
            if (start_val_i >= end_val_i) begin
              end_q         <= end_val_i;
              count_q       <= start_val_i;
              last_q        <= (start_val_i == end_val_i);
              count_valid_q <= 1'b1;
              busy_q        <= 1'b1;
              cfg_ready_q   <= 1'b0;
              state_q       <= S_STREAM;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (count_ready_i) begin
            if (last_q) begin
              count_valid_q <= 1'b0;
              last_q        <= 1'b0;
              done_q        <= 1'b1;
              state_q       <= S_DONE;
            end else begin
              // last is precomputed so it is registered alongside the new count
              count_q <= count_minus1;
              last_q  <= (count_minus1 == end_q);
            end
          end
        end
        S_DONE: begin
          busy_q      <= 1'b0;
          cfg_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q     <= S_IDLE;
          cfg_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cfg_ready_o   = cfg_ready_q;
  assign count_valid_o = count_valid_q;
  assign count_o       = count_q;
  assign last_o        = last_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;

`ifdef DECREMENT_RANGE_STREAMER_ASSERT_EN
  logic            chk_stall_q;
  logic            chk_valid_q;
  logic            chk_xfer_q;
  logic            chk_last_q;
  logic [Bits-1:0] chk_count_q;
  logic [Bits-1:0] chk_start_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chk_stall_q <= 1'b0;
      chk_valid_q <= 1'b0;
      chk_xfer_q  <= 1'b0;
      chk_last_q  <= 1'b0;
      chk_count_q <= '0;
      chk_start_q <= '0;
    end else begin
      chk_stall_q <= count_valid_o && !count_ready_i;
      chk_valid_q <= count_valid_o;
      chk_xfer_q  <= count_valid_o && count_ready_i;
      chk_last_q  <= last_o;
      chk_count_q <= count_o;
      if (cfg_valid_i && cfg_ready_o && (start_val_i >= end_val_i))
        chk_start_q <= start_val_i;
      if (chk_stall_q)
        assert (count_o == chk_count_q && last_o == chk_last_q)
          else $error("count_o/last_o changed during stall");
      if (chk_valid_q && !count_valid_o)
        assert (chk_xfer_q) else $error("count_valid_o dropped without transfer");
      if (count_valid_o)
        assert (count_o >= end_q && count_o <= chk_start_q)
          else $error("count_o outside configured range");
      if (cfg_valid_i && cfg_ready_o && (start_val_i < end_val_i))
        $warning("rejected config: start < end");
    end
  end
`endif

endmodule

`default_nettype wire
